// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder / fa_ha : bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fa_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic ab_x;

  assign ab_x = a ^ b;
  assign s    = ab_x ^ ci;
  assign co   = (a & b) | (ci & ab_x);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             c_q;
  logic [CNT_W-1:0] cnt;
  logic             s_bit, c_bit;
  logic             load, shift, last;

  fa_ha u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (c_q),
    .s  (s_bit),
    .co (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // start seen here restarts immediately with no IDLE gap
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c_q  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      s_sh <= '0;
      c_q  <= cin;
      cnt  <= '0;
    end else if (shift) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= {s_bit, s_sh[WIDTH-1:1]};
      c_q  <= c_bit;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Result registers only move on the final bit, so no partial sum is ever visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last) begin
      sum  <= {s_bit, s_sh[WIDTH-1:1]};
      cout <= c_bit;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs. arithmetic model.
`default_nettype none

module tb_serial_adder;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One addition from a single-cycle start; optionally scrambles inputs during RUN
  // and optionally pulses a second start at RUN cycle poke_at+1.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input bit scramble, input int poke_at, input string tag);
    logic [W:0] r;
    r = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      chk({tag, "_hold_sum"}, sum, exp_sum);
      chk({tag, "_hold_cout"}, cout, exp_cout);
      if (i == poke_at) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_cout"}, cout, exp_cout);
    tick();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    #9 rst_n = 1'b1;
    tick();

    run_add(8'h3C, 8'h05, 1'b0, 1'b0, -1, "basic");
    run_add(8'hFF, 8'h01, 1'b0, 1'b0, -1, "ripple1");
    run_add(8'hFF, 8'hFF, 1'b1, 1'b0, -1, "ripple2");
    run_add(8'h00, 8'h00, 1'b1, 1'b0, -1, "cin_only");

    run_add(8'h10, 8'h20, 1'b0, 1'b0, 2, "busy_start");
    for (int i = 0; i < 12; i++) begin
      chk("busy_start_no2nd_done", done, 0);
      chk("busy_start_no2nd_busy", busy, 0);
      tick();
    end

    // Back-to-back with start held high
    a = 8'd1; b = 8'd2; cin = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      chk("b2b1_busy", busy, 1);
      chk("b2b1_nodone", done, 0);
      tick();
    end
    chk("b2b1_done", done, 1);
    chk("b2b1_busy_low", busy, 0);
    chk("b2b1_sum", sum, 8'h03);
    a = 8'd7; b = 8'd9;
    tick();
    for (int i = 0; i < W; i++) begin
      chk("b2b2_busy", busy, 1);
      chk("b2b2_nodone", done, 0);
      chk("b2b2_hold", sum, 8'h03);
      tick();
    end
    chk("b2b2_done", done, 1);
    chk("b2b2_busy_low", busy, 0);
    chk("b2b2_sum", sum, 8'h10);
    chk("b2b2_cout", cout, 0);
    start = 1'b0;
    tick();
    chk("b2b_end_done", done, 0);
    chk("b2b_end_busy", busy, 0);

    // Asynchronous reset during RUN cycle 4
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    exp_sum = '0; exp_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_nodone", done, 0);
      chk("post_rst_idle", busy, 0);
    end
    run_add(8'h0F, 8'h01, 1'b0, 1'b0, -1, "after_rst");

    // Random operands against the arithmetic model, inputs wiggled during RUN
    for (int n = 0; n < 24; n++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), (n % 2) == 1, -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
